// File: rtl/mmio_arbiter.sv
// mmio_arbiter
// Shares the single MMIO slave bus between two bus masters. Each master
// performs one read or write per req/ack handshake. The arbiter latches the
// winning request, issues a one-cycle MMIO strobe, waits RD_LAT cycles for
// read data, then returns a one-cycle ack with the captured data.
//
// Build option: define MMIO_ARB_FIXED_PRIO_EN to make master 0 win every
// simultaneous request (fixed priority). Left undefined, simultaneous
// requests alternate round-robin on a one-bit last-grant pointer.
module mmio_arbiter #(
    parameter int ADDR_W = 21,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              m0_req,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              mmio_cs,
    output logic              mmio_write,
    output logic              mmio_read,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_write_data,
    input  logic [DATA_W-1:0] mmio_read_data,

    output logic              busy,
    output logic              grant_id
);

    // Read-latency counter: loaded with RD_LAT-1 on entry to WAIT and counted
    // down to zero, so WAIT lasts exactly RD_LAT cycles.
    localparam int         CNT_W    = 2;
    localparam int         LAT_LAST = (RD_LAT > 0) ? (RD_LAT - 1) : 0;
    localparam logic       ZERO_LAT = (RD_LAT == 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    logic               last_q;
    logic               grant_q;
    logic               write_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               m0_ack_q;
    logic               m1_ack_q;
    logic [DATA_W-1:0]  m0_rdata_q;
    logic [DATA_W-1:0]  m1_rdata_q;
    logic               mmio_cs_q;
    logic               mmio_write_q;
    logic               mmio_read_q;
    logic [ADDR_W-1:0]  mmio_addr_q;
    logic [DATA_W-1:0]  mmio_wdata_q;
    logic               busy_q;

    // Winner selection and the request fields it would latch in IDLE.
    logic               grant_d;
    logic               write_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  wdata_d;

    // Pick the winner among current requesters and mux its request fields.
    always_comb begin
        grant_d = 1'b0;
        if (m0_req && m1_req) begin
`ifdef MMIO_ARB_FIXED_PRIO_EN
            grant_d = 1'b0;
`else
            grant_d = ~last_q;
`endif
        end else if (m1_req) begin
            grant_d = 1'b1;
        end
        write_d = grant_d ? m1_write : m0_write;
        addr_d  = grant_d ? m1_addr  : m0_addr;
        wdata_d = grant_d ? m1_wdata : m0_wdata;
    end

    // Arbiter FSM; every output is a register set on entry to the state that
    // drives it, and returns to 0 by default on the following edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b1;
            grant_q      <= 1'b0;
            write_q      <= 1'b0;
            cnt_q        <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            mmio_cs_q    <= 1'b0;
            mmio_write_q <= 1'b0;
            mmio_read_q  <= 1'b0;
            mmio_addr_q  <= '0;
            mmio_wdata_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            // Strobes, acks and returned data are single-cycle pulses.
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            mmio_cs_q    <= 1'b0;
            mmio_write_q <= 1'b0;
            mmio_read_q  <= 1'b0;
            mmio_addr_q  <= '0;
            mmio_wdata_q <= '0;
            busy_q       <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (m0_req || m1_req) begin
                        state_q      <= ST_ISSUE;
                        grant_q      <= grant_d;
                        last_q       <= grant_d;
                        write_q      <= write_d;
                        mmio_cs_q    <= 1'b1;
                        mmio_write_q <= write_d;
                        mmio_read_q  <= ~write_d;
                        mmio_addr_q  <= addr_d;
                        mmio_wdata_q <= wdata_d;
                        busy_q       <= 1'b1;
                    end
                end

                ST_ISSUE: begin
                    busy_q <= 1'b1;
                    if (write_q) begin
                        state_q  <= ST_DONE;
                        m0_ack_q <= ~grant_q;
                        m1_ack_q <= grant_q;
                    end else if (ZERO_LAT) begin
                        // Combinational slave: data is valid during the strobe.
                        state_q  <= ST_DONE;
                        m0_ack_q <= ~grant_q;
                        m1_ack_q <= grant_q;
                        if (grant_q) begin
                            m1_rdata_q <= mmio_read_data;
                        end else begin
                            m0_rdata_q <= mmio_read_data;
                        end
                    end else begin
                        state_q <= ST_WAIT;
                        cnt_q   <= CNT_W'(LAT_LAST);
                    end
                end

                ST_WAIT: begin
                    busy_q <= 1'b1;
                    if (cnt_q == '0) begin
                        state_q  <= ST_DONE;
                        m0_ack_q <= ~grant_q;
                        m1_ack_q <= grant_q;
                        if (grant_q) begin
                            m1_rdata_q <= mmio_read_data;
                        end else begin
                            m0_rdata_q <= mmio_read_data;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                ST_DONE: begin
                    // Always pass through IDLE so a held req is a new transaction.
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_ack          = m0_ack_q;
    assign m1_ack          = m1_ack_q;
    assign m0_rdata        = m0_rdata_q;
    assign m1_rdata        = m1_rdata_q;
    assign mmio_cs         = mmio_cs_q;
    assign mmio_write      = mmio_write_q;
    assign mmio_read       = mmio_read_q;
    assign mmio_addr       = mmio_addr_q;
    assign mmio_write_data = mmio_wdata_q;
    assign busy            = busy_q;
    assign grant_id        = grant_q;

endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter
// Directed bench for mmio_arbiter with RD_LAT=1. A small slave model returns
// 0x12345678 ^ address one cycle after a read strobe and 0xFFFFFFFF otherwise.
// Expectations for contention follow MMIO_ARB_FIXED_PRIO_EN when it is defined.
module tb_mmio_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m0_write, m1_req, m1_write;
    logic [20:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mmio_cs, mmio_write, mmio_read;
    logic [20:0] mmio_addr;
    logic [31:0] mmio_write_data;
    logic [31:0] slave_q = 32'hFFFF_FFFF;
    logic        busy, grant_id;
    logic [5:0]  ctl;

    int checks = 0;
    int errors = 0;

    mmio_arbiter #(.ADDR_W(21), .DATA_W(32), .RD_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mmio_cs(mmio_cs), .mmio_write(mmio_write), .mmio_read(mmio_read),
        .mmio_addr(mmio_addr), .mmio_write_data(mmio_write_data),
        .mmio_read_data(slave_q),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    // Slave with one cycle of read latency; garbage outside the data cycle.
    always @(posedge clk) begin
        slave_q <= mmio_read ? (32'h1234_5678 ^ {11'h0, mmio_addr}) : 32'hFFFF_FFFF;
    end

    // {busy, cs, write, read, m0_ack, m1_ack}
    assign ctl = {busy, mmio_cs, mmio_write, mmio_read, m0_ack, m1_ack};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        m0_req = 1'b0; m0_write = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_write = 1'b0; m1_addr = '0; m1_wdata = '0;
        repeat (3) tick();
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL reset_ctl: got %b expected 000000", ctl); end
        checks++; if (mmio_addr !== 21'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mmio_addr); end
        checks++; if (mmio_write_data !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", mmio_write_data); end
        checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h %h expected 0 0", m0_rdata, m1_rdata); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0", grant_id); end
        reset_n = 1'b1;
        tick();
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL reset_idle: got %b expected 000000", ctl); end
    endtask

    task automatic test_m0_write();
        m0_req = 1'b1; m0_write = 1'b1; m0_addr = 21'h00010; m0_wdata = 32'hDEAD_BEEF;
        tick();
        checks++; if (ctl !== 6'b111000) begin errors++; $display("FAIL wr_issue_ctl: got %b expected 111000", ctl); end
        checks++; if (mmio_addr !== 21'h00010) begin errors++; $display("FAIL wr_issue_addr: got %h expected 00010", mmio_addr); end
        checks++; if (mmio_write_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_issue_data: got %h expected deadbeef", mmio_write_data); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL wr_grant: got %b expected 0", grant_id); end
        tick();
        checks++; if (ctl !== 6'b100010) begin errors++; $display("FAIL wr_done_ctl: got %b expected 100010", ctl); end
        checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h expected 0", m0_rdata); end
        m0_req = 1'b0;
        tick();
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL wr_after_ctl: got %b expected 000000", ctl); end
    endtask

    task automatic test_m1_read();
        m1_req = 1'b1; m1_write = 1'b0; m1_addr = 21'h0;
        tick();
        checks++; if (ctl !== 6'b110100) begin errors++; $display("FAIL rd_issue_ctl: got %b expected 110100", ctl); end
        checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL rd_grant: got %b expected 1", grant_id); end
        tick();
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL rd_wait_ctl: got %b expected 100000", ctl); end
        tick();
        checks++; if (ctl !== 6'b100001) begin errors++; $display("FAIL rd_done_ctl: got %b expected 100001", ctl); end
        checks++; if (m1_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_data: got %h expected 12345678", m1_rdata); end
        checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL rd_other_rdata: got %h expected 0", m0_rdata); end
        m1_req = 1'b0;
        tick();
        checks++; if ({ctl, m1_rdata} !== 38'h0) begin errors++; $display("FAIL rd_after: got %b %h expected 000000 0", ctl, m1_rdata); end
        checks++; if (grant_id !== 1'b1) begin errors++; $display("FAIL rd_grant_hold: got %b expected 1", grant_id); end
    endtask

    task automatic test_contention();
        int seq [8];
        int exp_seq [8];
        int nacks = 0;
        int nissue = 0;
        int n0 = 0;
        int n1 = 0;
        logic prev_ack = 1'b0;
        logic [20:0] exp_addr;
        for (int i = 0; i < 8; i++) begin
`ifdef MMIO_ARB_FIXED_PRIO_EN
            exp_seq[i] = (i >= 4) ? 1 : 0;
`else
            exp_seq[i] = i % 2;
`endif
        end
        m0_req = 1'b1; m0_write = 1'b1; m0_addr = 21'h00100; m0_wdata = 32'h0000_0A0A;
        m1_req = 1'b1; m1_write = 1'b1; m1_addr = 21'h00200; m1_wdata = 32'h0000_0B0B;
        for (int cyc = 0; cyc < 60 && nacks < 8; cyc++) begin
            tick();
            if (!busy) begin
                checks++;
                if ({mmio_cs, mmio_write, mmio_read} !== 3'b000) begin
                    errors++; $display("FAIL cont_idle_strobe: got %b expected 000", {mmio_cs, mmio_write, mmio_read});
                end
            end
            if (mmio_cs && nissue < 8) begin
                exp_addr = (exp_seq[nissue] == 1) ? 21'h00200 : 21'h00100;
                checks++;
                if (mmio_addr !== exp_addr) begin
                    errors++; $display("FAIL cont_addr[%0d]: got %h expected %h", nissue, mmio_addr, exp_addr);
                end
                nissue++;
            end
            if (m0_ack || m1_ack) begin
                checks++; if (prev_ack) begin errors++; $display("FAIL cont_ack_width: got 2-cycle ack expected 1-cycle"); end
                checks++; if (m0_ack && m1_ack) begin errors++; $display("FAIL cont_dual_ack: got both expected one"); end
                seq[nacks] = m1_ack ? 1 : 0;
                nacks++;
                if (m0_ack) begin n0++; if (n0 == 4) m0_req = 1'b0; end
                if (m1_ack) begin n1++; if (n1 == 4) m1_req = 1'b0; end
            end
            prev_ack = m0_ack | m1_ack;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        checks++; if (nacks != 8) begin errors++; $display("FAIL cont_count: got %0d acks expected 8", nacks); end
        for (int i = 0; i < nacks; i++) begin
            checks++;
            if (seq[i] != exp_seq[i]) begin errors++; $display("FAIL cont_order[%0d]: got m%0d expected m%0d", i, seq[i], exp_seq[i]); end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        m0_req = 1'b1; m0_write = 1'b0; m0_addr = 21'h00007;
        tick();
        checks++; if (ctl !== 6'b110100) begin errors++; $display("FAIL mid_issue_ctl: got %b expected 110100", ctl); end
        tick();
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL mid_wait_ctl: got %b expected 100000", ctl); end
        reset_n = 1'b0; m0_req = 1'b0;
        tick();
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL mid_reset_ctl: got %b expected 000000", ctl); end
        checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin errors++; $display("FAIL mid_reset_rdata: got %h %h expected 0 0", m0_rdata, m1_rdata); end
        checks++; if ({mmio_addr, mmio_write_data, grant_id} !== 54'h0) begin errors++; $display("FAIL mid_reset_bus: got %h %h %b expected 0 0 0", mmio_addr, mmio_write_data, grant_id); end
        tick();
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL mid_reset_hold: got %b expected 000000", ctl); end
        reset_n = 1'b1;
        m0_req = 1'b1; m0_write = 1'b1; m0_addr = 21'h00020; m0_wdata = 32'hA5A5_A5A5;
        m1_req = 1'b1; m1_write = 1'b0; m1_addr = 21'h00005;
        tick();
        checks++; if ({ctl, grant_id} !== 7'b1110000) begin errors++; $display("FAIL post_first_grant: got %b/%b expected 111000/0", ctl, grant_id); end
        checks++; if (mmio_write_data !== 32'hA5A5_A5A5) begin errors++; $display("FAIL post_wdata: got %h expected a5a5a5a5", mmio_write_data); end
        tick();
        checks++; if (ctl !== 6'b100010) begin errors++; $display("FAIL post_m0_done: got %b expected 100010", ctl); end
        m0_req = 1'b0;
        tick();
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL post_idle: got %b expected 000000", ctl); end
        tick();
        checks++; if ({ctl, grant_id} !== 7'b1101001) begin errors++; $display("FAIL post_m1_issue: got %b/%b expected 110100/1", ctl, grant_id); end
        checks++; if (mmio_addr !== 21'h00005) begin errors++; $display("FAIL post_m1_addr: got %h expected 00005", mmio_addr); end
        tick();
        checks++; if (ctl !== 6'b100000) begin errors++; $display("FAIL post_m1_wait: got %b expected 100000", ctl); end
        tick();
        checks++; if (ctl !== 6'b100001) begin errors++; $display("FAIL post_m1_done: got %b expected 100001", ctl); end
        checks++; if (m1_rdata !== 32'h1234_567D) begin errors++; $display("FAIL post_m1_data: got %h expected 1234567d", m1_rdata); end
        m1_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back_hold();
        m0_req = 1'b1; m0_write = 1'b1; m0_addr = 21'h00030; m0_wdata = 32'h0BAD_F00D;
        tick();
        checks++; if (ctl !== 6'b111000) begin errors++; $display("FAIL hold_issue1: got %b expected 111000", ctl); end
        tick();
        checks++; if (ctl !== 6'b100010) begin errors++; $display("FAIL hold_done1: got %b expected 100010", ctl); end
        tick();
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL hold_idle_gap: got %b expected 000000", ctl); end
        tick();
        checks++; if (ctl !== 6'b111000) begin errors++; $display("FAIL hold_issue2: got %b expected 111000", ctl); end
        checks++; if ({mmio_addr, mmio_write_data} !== {21'h00030, 32'h0BAD_F00D}) begin errors++; $display("FAIL hold_issue2_bus: got %h %h expected 00030 0badf00d", mmio_addr, mmio_write_data); end
        m0_req = 1'b0;
        tick();
        checks++; if (ctl !== 6'b100010) begin errors++; $display("FAIL hold_done2: got %b expected 100010", ctl); end
        tick();
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL hold_idle_end: got %b expected 000000", ctl); end
        tick();
        checks++; if (ctl !== 6'b000000) begin errors++; $display("FAIL hold_no_third: got %b expected 000000", ctl); end
    endtask

    initial begin
        test_reset();
        test_m0_write();
        test_m1_read();
        test_contention();
        test_reset_mid();
        test_back_to_back_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
